// File: rtl/intc_vec.sv
// Vectored interrupt controller: level/edge sources, sticky edge latches,
// W1C and force, and a claim register that acknowledges the winning source.
module intc_vec #(
  parameter int N_IRQ       = 2,
  parameter int SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic [2:0]        avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [31:0]       avl_writedata,
  output logic              avl_irq,
  output logic [31:0]       avl_readdata
);

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] r_p;
  logic [N_IRQ-1:0] r_en;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_lat;
  logic [N_IRQ-1:0] w_pnd;
  logic [N_IRQ-1:0] w_status;
  logic [N_IRQ-1:0] w_wd;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_clm;
  logic [N_IRQ-1:0] w_mode_nx;
  logic [N_IRQ-1:0] w_en_nx;
  logic             w_valid;
  logic [4:0]       w_id;
  logic             w_we_en;
  logic             w_we_pnd;
  logic             w_we_mode;
  logic             w_we_frc;
  logic             w_claim;
  logic             w_unused;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = irq_in;
    end else begin : g_sync
      logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++)
            r_sync[k] <= '0;
        end else begin
          r_sync[0] <= irq_in;
          for (int k = 1; k < SYNC_STAGES; k++)
            r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_wd      = avl_writedata[N_IRQ-1:0];
  assign w_unused  = ^avl_writedata;
  assign w_we_en   = avl_write && (avl_address == 3'd1);
  assign w_we_pnd  = avl_write && (avl_address == 3'd2);
  assign w_we_mode = avl_write && (avl_address == 3'd3);
  assign w_we_frc  = avl_write && (avl_address == 3'd5);
  assign w_claim   = avl_read && (avl_address == 3'd4);

  assign w_pnd    = (r_mode & r_lat) | (~r_mode & w_s);
  assign w_status = w_pnd & r_en;
  assign w_valid  = |w_status;
  assign avl_irq  = w_valid;

  always_comb begin
    w_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (w_status[i]) w_id = 5'(i);
  end

  always_comb begin
    w_clm = '0;
    for (int i = 0; i < N_IRQ; i++)
      w_clm[i] = w_claim && w_valid && (w_id == 5'(i));
  end

  assign w_set     = (w_s & ~r_p) | (w_we_frc ? w_wd : '0);
  assign w_clr     = (w_we_pnd ? w_wd : '0) | w_clm;
  assign w_mode_nx = w_we_mode ? w_wd : r_mode;
  assign w_en_nx   = w_we_en ? w_wd : r_en;

  // Latch only runs while in edge mode both before and after this edge,
  // so a mode switch in either direction leaves it clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p    <= '0;
      r_en   <= '0;
      r_mode <= '0;
      r_lat  <= '0;
    end else begin
      r_p    <= w_s;
      r_en   <= w_en_nx;
      r_mode <= w_mode_nx;
      r_lat  <= (w_set | (r_lat & ~w_clr)) & r_mode & w_mode_nx;
    end
  end

  always_comb begin
    avl_readdata = '0;
    case (avl_address)
      3'd0: avl_readdata[N_IRQ-1:0] = w_status;
      3'd1: avl_readdata[N_IRQ-1:0] = r_en;
      3'd2: avl_readdata[N_IRQ-1:0] = w_pnd;
      3'd3: avl_readdata[N_IRQ-1:0] = r_mode;
      3'd4: avl_readdata = {w_valid, 26'b0, w_valid ? w_id : 5'd0};
      default: avl_readdata = '0;
    endcase
  end

endmodule

// File: doc/intc_vec.md
# intc_vec

Parametrised interrupt controller for up to 32 sources: per-source enable, per-source level/edge mode, sticky edge pending with write-1-to-clear and software force, and a claim register that returns and acknowledges the highest-priority pending source. Sits on the Avalon-MM slave fabric beside the timer and JTAG UART and drives the CPU's single interrupt line.

## Interface

- N_IRQ, 2: number of interrupt sources, 1..32; source i sits on bit i of every register.
- SYNC_STAGES, 0: flip-flop synchroniser depth on each `irq_in` bit. 0 means the inputs are already in the `clk` domain.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt requests, active high.
- avl_address  in  3  word register index.
- avl_read  in  1  read strobe.
- avl_write  in  1  write strobe.
- avl_writedata  in  32  write data.
- avl_irq  out  1  OR of STATUS, to CPU.
- avl_readdata  out  32  combinational read data, zero wait states.

## Operation

- Terms:
  - s: the synchronised input. It equals `irq_in` when SYNC_STAGES=0, otherwise it is the output of the last synchroniser stage.
  - p: the previous-cycle copy of s. It updates every cycle regardless of mode.
  - Edge: detected on bit i when s[i]=1 and p[i]=0.
- Per-source pending value PND[i]:
  - Level mode (MODE[i]=0): PND[i] = s[i]. It is not latched, and W1C and FORCE have no effect.
  - Edge mode (MODE[i]=1): PND[i] is a latch. It is set by an edge or by FORCE, and cleared by W1C or by a claim acknowledge.
  - Set has priority over clear in the same cycle.
- STATUS = PND & ENABLE; avl_irq = |STATUS.
- Register map (avl_address):
  - 0 STATUS: read-only.
  - 1 ENABLE: read/write.
  - 2 PENDING: reads PND. Writing 1 to a bit clears the edge latch for that bit.
  - 3 MODE: read/write; 1=edge, 0=level.
  - 4 CLAIM: read-only. Returns {valid, 26'b0, id[4:0]}, where id is the lowest index with STATUS set. If STATUS=0, it returns 0 with valid=0.
  - 5 FORCE: write-only; writing 1 sets the edge latch. Reads return 0.
  - 6, 7: unmapped; read 0, writes ignored.
- CLAIM side effect: a cycle with avl_read=1 and address=4 clears the latch of the returned id on that clock edge, if that source is in edge mode. It has no effect on level sources or when valid=0.
- Width rules:
  - Bits ≥ N_IRQ of every register read 0.
  - Writes to bits ≥ N_IRQ are ignored.
- Switching a source from level to edge does not create a spurious pending, because p is always tracking. The latch starts at 0 after a switch.
- Switching a source from edge to level discards its latch: the latch is cleared on the write cycle.

## Timing

- Reset (rst high, asynchronous): ENABLE, MODE, latches, p and synchroniser stages are all cleared to 0.
  - avl_irq = 0.
  - avl_readdata reflects the reset register state, i.e. 0 for all addresses given an idle input.
- Input to s latency: SYNC_STAGES cycles.
- Edge source:
  - An edge seen on s at cycle n sets the latch at the end of cycle n.
  - STATUS and avl_irq go high in cycle n+1 (when enabled).
- Level source: avl_irq follows s combinationally through ENABLE, with zero added cycles.
- Register writes take effect at the clock edge. The new value is visible in readdata and avl_irq the following cycle.
- Reads are combinational in the same cycle as avl_read. CLAIM's clear is visible from the next cycle.
- Simultaneous events on one edge-mode bit in the same cycle (new edge or FORCE, together with W1C or claim): the bit ends up set.
- Reset asserted mid-transaction aborts it. No write lands and no claim-clear occurs.

## Test plan

- Reset, N_IRQ=2: readdata is 0 at all 8 addresses and avl_irq=0. Then write ENABLE=0xFFFFFFFF → read back 0x3.
- Level mode: ENABLE=0x1 with irq_in=01 → STATUS=0x1 and avl_irq=1. Drop irq_in → avl_irq=0 the same cycle. A W1C to PENDING has no effect.
- Edge mode: MODE=0x3, ENABLE=0x3, 1-cycle pulse on irq_in[1] → PND=0x2 and stays set. W1C 0x2 → PND=0, avl_irq=0 the next cycle.
- Claim: both edge latches set → CLAIM returns 0x80000000 and then 0x80000001 on successive reads. A third read returns 0 and avl_irq=0.
- Collision: W1C bit 0 in the same cycle as a new edge on irq_in[0] → bit 0 remains set. FORCE=0x1 with ENABLE=0 → PND=0x1, STATUS=0, avl_irq=0.
- N_IRQ=32, SYNC_STAGES=2: edge on irq_in[31] → CLAIM returns 0x8000001F, with avl_irq rising exactly 3 cycles after the input edge.
